// File: rtl/sys_cmd_ctrl_if.sv
// Bus bundle between the command controller and the register file, ALU, RX path and TX FIFO.
// The controller uses the master view; the surrounding blocks (or a bench) use the slave view.
interface sys_cmd_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned ALU_WIDTH  = 16,
    parameter int unsigned FUN_WIDTH  = 4
) ();
    // RX path
    logic [DATA_WIDTH-1:0] RX_P_DATA;
    logic                  RX_D_VLD;
    // Register file
    logic [DATA_WIDTH-1:0] RdData;
    logic                  RdData_Valid;
    logic [ADDR_WIDTH-1:0] Address;
    logic                  WrEn;
    logic                  RdEn;
    logic [DATA_WIDTH-1:0] WrData;
    // ALU
    logic [ALU_WIDTH-1:0]  ALU_OUT;
    logic                  ALU_OUT_VLD;
    logic                  ALU_EN;
    logic [FUN_WIDTH-1:0]  ALU_FUN;
    logic                  CLK_EN;
    // TX FIFO
    logic                  FIFO_FULL;
    logic [DATA_WIDTH-1:0] TX_P_DATA;
    logic                  TX_D_VLD;

    modport master (
        input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
        output Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
        input  Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD
    );
endinterface

// File: rtl/sys_cmd_ctrl.sv
// Receive-side command controller: decodes AA (write), BB (read), CC (ALU with operands) and
// DD (ALU, no operands) frames from the RX byte stream, drives the register file and ALU,
// and pushes the response bytes (read data, or ALU result LSB first) into the TX FIFO.
module sys_cmd_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned ALU_WIDTH  = 16,
    parameter int unsigned FUN_WIDTH  = 4
) (
    input  logic           CLK,
    input  logic           RST_N,
    sys_cmd_ctrl_if.master bus
);

    localparam logic [DATA_WIDTH-1:0] CmdWrite  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CmdRead   = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CmdAluOp  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CmdAluNop = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        StIdle,
        StWrAddr,
        StWrData,
        StRdAddr,
        StRdWait,
        StOpA,
        StOpB,
        StAluFun,
        StAluWait,
        StTxLo,
        StTxHi
    } state_e;

    state_e                state_q;
    // Byte waiting for the final push in StTxHi (ALU upper byte or register read data).
    logic [DATA_WIDTH-1:0] stage_q;

    // Command FSM with all outputs registered; strobes default low so each is a one-cycle pulse.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q       <= StIdle;
            stage_q       <= '0;
            bus.Address   <= '0;
            bus.WrEn      <= 1'b0;
            bus.RdEn      <= 1'b0;
            bus.WrData    <= '0;
            bus.ALU_EN    <= 1'b0;
            bus.ALU_FUN   <= '0;
            bus.CLK_EN    <= 1'b0;
            bus.TX_P_DATA <= '0;
            bus.TX_D_VLD  <= 1'b0;
        end else begin
            bus.WrEn     <= 1'b0;
            bus.RdEn     <= 1'b0;
            bus.ALU_EN   <= 1'b0;
            bus.TX_D_VLD <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.RX_D_VLD) begin
                        case (bus.RX_P_DATA)
                            CmdWrite:  state_q <= StWrAddr;
                            CmdRead:   state_q <= StRdAddr;
                            CmdAluOp:  state_q <= StOpA;
                            CmdAluNop: state_q <= StAluFun;
                            default:   state_q <= StIdle;
                        endcase
                    end
                end
                StWrAddr: begin
                    if (bus.RX_D_VLD) begin
                        bus.Address <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
                        state_q     <= StWrData;
                    end
                end
                StWrData: begin
                    if (bus.RX_D_VLD) begin
                        bus.WrData <= bus.RX_P_DATA;
                        bus.WrEn   <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                StRdAddr: begin
                    if (bus.RX_D_VLD) begin
                        bus.Address <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
                        bus.RdEn    <= 1'b1;
                        state_q     <= StRdWait;
                    end
                end
                StRdWait: begin
                    // Read reply is a single byte, so it goes straight to the final push state.
                    if (bus.RdData_Valid) begin
                        stage_q <= bus.RdData;
                        state_q <= StTxHi;
                    end
                end
                StOpA: begin
                    if (bus.RX_D_VLD) begin
                        bus.Address <= '0;
                        bus.WrData  <= bus.RX_P_DATA;
                        bus.WrEn    <= 1'b1;
                        state_q     <= StOpB;
                    end
                end
                StOpB: begin
                    if (bus.RX_D_VLD) begin
                        bus.Address <= ADDR_WIDTH'(1);
                        bus.WrData  <= bus.RX_P_DATA;
                        bus.WrEn    <= 1'b1;
                        state_q     <= StAluFun;
                    end
                end
                StAluFun: begin
                    if (bus.RX_D_VLD) begin
                        bus.ALU_FUN <= bus.RX_P_DATA[FUN_WIDTH-1:0];
                        bus.ALU_EN  <= 1'b1;
                        bus.CLK_EN  <= 1'b1;
                        state_q     <= StAluWait;
                    end
                end
                StAluWait: begin
                    // Low byte goes onto TX_P_DATA now so it is stable for the whole FIFO stall.
                    if (bus.ALU_OUT_VLD) begin
                        bus.CLK_EN    <= 1'b0;
                        bus.TX_P_DATA <= bus.ALU_OUT[DATA_WIDTH-1:0];
                        stage_q       <= bus.ALU_OUT[ALU_WIDTH-1:DATA_WIDTH];
                        state_q       <= StTxLo;
                    end
                end
                StTxLo: begin
                    if (!bus.FIFO_FULL) begin
                        bus.TX_D_VLD <= 1'b1;
                        state_q      <= StTxHi;
                    end
                end
                StTxHi: begin
                    if (!bus.FIFO_FULL) begin
                        bus.TX_P_DATA <= stage_q;
                        bus.TX_D_VLD  <= 1'b1;
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Bench for sys_cmd_ctrl: command-level reference model feeding an expected-event queue,
// register-file / ALU / FIFO responders, and a monitor that checks every DUT strobe.
module tb_sys_cmd_ctrl;

    localparam int KWr = 0, KRd = 1, KAlu = 2, KTx = 3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    logic REF_CLK_TB = 1'b0;
    logic RST_N_TB;

    sys_cmd_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_WIDTH(16), .FUN_WIDTH(4)) bus ();

    sys_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_WIDTH(16), .FUN_WIDTH(4)) dut (
        .CLK   (REF_CLK_TB),
        .RST_N (RST_N_TB),
        .bus   (bus)
    );

    always #5 REF_CLK_TB = ~REF_CLK_TB;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    logic [7:0] mem   [16] = '{default: 8'h00};  // reference model register contents
    logic [7:0] tb_rf [16] = '{default: 8'h00};  // responder register file
    int   full_mode = 2;                         // 0 random, 1 forced full, 2 never full
    logic full_at_edge = 1'b0;
    int   alu_fire_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // External ALU behaviour assumed by the bench.
    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] f);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            4'd3:    return 16'(a & b);
            4'd4:    return 16'(a | b);
            4'd5:    return 16'(a ^ b);
            default: return {a, b};
        endcase
    endfunction

    // FIFO full driver
    initial begin
        bus.FIFO_FULL = 1'b0;
        forever begin
            @(posedge REF_CLK_TB);
            #1;
            case (full_mode)
                0:       bus.FIFO_FULL = ($urandom_range(0, 2) == 0);
                1:       bus.FIFO_FULL = 1'b1;
                default: bus.FIFO_FULL = 1'b0;
            endcase
        end
    end

    always @(posedge REF_CLK_TB) full_at_edge <= bus.FIFO_FULL;

    // Register-file responder: stores writes, answers reads after a few cycles
    always @(negedge REF_CLK_TB) if (RST_N_TB && bus.WrEn) tb_rf[bus.Address] <= bus.WrData;

    initial begin
        logic [3:0] ra;
        bus.RdData       = 8'h00;
        bus.RdData_Valid = 1'b0;
        forever begin
            @(negedge REF_CLK_TB);
            if (RST_N_TB && bus.RdEn) begin
                ra = bus.Address;
                repeat ($urandom_range(3, 6)) @(posedge REF_CLK_TB);
                #1;
                bus.RdData       = tb_rf[ra];
                bus.RdData_Valid = 1'b1;
                @(posedge REF_CLK_TB);
                #1;
                bus.RdData_Valid = 1'b0;
                bus.RdData       = 8'($urandom);
            end
        end
    end

    // ALU responder
    initial begin
        logic [3:0] fn;
        bus.ALU_OUT     = 16'h0000;
        bus.ALU_OUT_VLD = 1'b0;
        forever begin
            @(negedge REF_CLK_TB);
            if (RST_N_TB && bus.ALU_EN) begin
                fn = bus.ALU_FUN;
                repeat ($urandom_range(3, 6)) @(posedge REF_CLK_TB);
                #1;
                bus.ALU_OUT     = alu_fn(tb_rf[0], tb_rf[1], fn);
                bus.ALU_OUT_VLD = 1'b1;
                alu_fire_cnt++;
                @(posedge REF_CLK_TB);
                #1;
                bus.ALU_OUT_VLD = 1'b0;
                bus.ALU_OUT     = 16'($urandom);
            end
        end
    end

    // Monitor: every strobe must match the next expected event
    always @(negedge REF_CLK_TB) begin
        int   ns;
        int   act_kind;
        exp_t e;
        if (RST_N_TB) begin
            ns = int'(bus.WrEn) + int'(bus.RdEn) + int'(bus.ALU_EN) + int'(bus.TX_D_VLD);
            if (bus.ALU_OUT_VLD) check("clk_en_wait", 32'(bus.CLK_EN), 1);
            if (ns != 0) begin
                check("one_strobe", ns, 1);
                if (bus.TX_D_VLD) check("tx_not_full", 32'(full_at_edge), 0);
                check("queue_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    act_kind = bus.WrEn ? KWr : bus.RdEn ? KRd : bus.ALU_EN ? KAlu : KTx;
                    check("strobe_kind", act_kind, 32'(e.kind));
                    if (act_kind == int'(e.kind)) begin
                        case (act_kind)
                            KWr: begin
                                check("wr_addr", 32'(bus.Address), 32'(e.addr));
                                check("wr_data", 32'(bus.WrData), 32'(e.data));
                            end
                            KRd: check("rd_addr", 32'(bus.Address), 32'(e.addr));
                            KAlu: begin
                                check("alu_fun", 32'(bus.ALU_FUN), 32'(e.data));
                                check("alu_clk_en", 32'(bus.CLK_EN), 1);
                            end
                            default: begin
                                check("tx_data", 32'(bus.TX_P_DATA), 32'(e.data));
                                check("tx_clk_en", 32'(bus.CLK_EN), 0);
                            end
                        endcase
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge REF_CLK_TB);
        #1;
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        @(posedge REF_CLK_TB);
        #1;
        bus.RX_D_VLD  = 1'b0;
        bus.RX_P_DATA = 8'($urandom);
    endtask

    task automatic send_junk();
        case ($urandom_range(0, 4))
            0:       send_byte(8'hAA);
            1:       send_byte(8'hBB);
            2:       send_byte(8'hCC);
            3:       send_byte(8'hDD);
            default: send_byte(8'($urandom));
        endcase
    endtask

    task automatic push(input int k, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.kind = 2'(k);
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_alu(input logic [7:0] f);
        logic [15:0] r;
        r = alu_fn(mem[0], mem[1], f[3:0]);
        push(KAlu, 8'h00, {4'h0, f[3:0]});
        push(KTx, 8'h00, r[7:0]);
        push(KTx, 8'h00, r[15:8]);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        push(KWr, {4'h0, a[3:0]}, d);
        mem[a[3:0]] = d;
        send_byte(8'hAA);
        send_byte(a);
        send_byte(d);
    endtask

    task automatic do_read(input logic [7:0] a, input bit junk);
        push(KRd, {4'h0, a[3:0]}, 8'h00);
        push(KTx, 8'h00, mem[a[3:0]]);
        send_byte(8'hBB);
        send_byte(a);
        if (junk) send_junk();
    endtask

    task automatic do_alu_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f,
                             input bit junk);
        push(KWr, 8'h00, a);
        push(KWr, 8'h01, b);
        mem[0] = a;
        mem[1] = b;
        push_alu(f);
        send_byte(8'hCC);
        send_byte(a);
        send_byte(b);
        send_byte(f);
        if (junk) send_junk();
    endtask

    task automatic do_alu_nop(input logic [7:0] f, input bit junk);
        push_alu(f);
        send_byte(8'hDD);
        send_byte(f);
        if (junk) send_junk();
    endtask

    task automatic wait_idle();
        int t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(posedge REF_CLK_TB);
            t++;
        end
        check("drain", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(posedge REF_CLK_TB);
    endtask

    task automatic check_reset_outputs(input string name);
        @(negedge REF_CLK_TB);
        check(name, {bus.Address, bus.WrEn, bus.RdEn, bus.WrData, bus.ALU_EN, bus.ALU_FUN,
                     bus.CLK_EN, bus.TX_P_DATA, bus.TX_D_VLD}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         f0;
        int         t;
        bit         seen;
        logic [7:0] held;
        logic [7:0] a, b, f;

        bus.RX_P_DATA = 8'h00;
        bus.RX_D_VLD  = 1'b0;
        RST_N_TB      = 1'b0;
        repeat (3) @(posedge REF_CLK_TB);
        check_reset_outputs("reset_outputs");
        @(posedge REF_CLK_TB);
        #1;
        RST_N_TB = 1'b1;

        // Directed cases, FIFO never full
        do_write(8'h05, 8'h0A);
        wait_idle();
        do_read(8'h05, 1'b0);
        wait_idle();
        do_alu_op(8'h01, 8'h02, 8'h00, 1'b0);  // 0x0003 -> 03, 00
        wait_idle();
        do_alu_nop(8'h02, 1'b0);               // 1*2 -> 02, 00
        wait_idle();
        send_byte(8'h55);                      // ignored
        wait_idle();

        // FIFO stall during TX_LO
        full_mode = 1;
        f0 = alu_fire_cnt;
        do_alu_op(8'h34, 8'h12, 8'h01, 1'b1);
        t = 0;
        while (alu_fire_cnt == f0 && t < 50) begin
            @(negedge REF_CLK_TB);
            t++;
        end
        check("alu_response_seen", 32'(alu_fire_cnt != f0), 1);
        @(posedge REF_CLK_TB);
        for (int i = 0; i < 10; i++) begin
            @(negedge REF_CLK_TB);
            if (i == 0) held = bus.TX_P_DATA;
            else check("stall_data_stable", 32'(bus.TX_P_DATA), 32'(held));
            check("stall_no_push", 32'(bus.TX_D_VLD), 0);
        end
        full_mode = 2;
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge REF_CLK_TB);
            if (bus.TX_D_VLD) seen = 1'b1;
        end
        check("push_after_release", 32'(seen), 1);
        wait_idle();

        // Reset in the middle of a write aborts it
        send_byte(8'hAA);
        send_byte(8'h05);
        @(posedge REF_CLK_TB);
        #1;
        RST_N_TB = 1'b0;
        repeat (2) @(posedge REF_CLK_TB);
        check_reset_outputs("abort_reset_outputs");
        @(posedge REF_CLK_TB);
        #1;
        RST_N_TB = 1'b1;
        do_write(8'h03, 8'h07);
        wait_idle();
        do_read(8'h03, 1'b1);
        wait_idle();

        // Randomized traffic with random FIFO back-pressure
        full_mode = 0;
        for (int i = 0; i < 80; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            f = 8'($urandom_range(0, 8)) | (8'($urandom_range(0, 15)) << 4);
            case ($urandom_range(0, 4))
                0: do_write(a, b);
                1: do_read(a, 1'($urandom));
                2: do_alu_op(a, b, f, 1'($urandom));
                3: do_alu_nop(f, 1'($urandom));
                default: begin
                    do b = 8'($urandom); while (b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD});
                    send_byte(b);
                end
            endcase
            wait_idle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
